// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the instruction fetch stage.
//   fetch_entry_t : instruction FIFO entry {inst, pc, trap}
//   fetch_state_e : fetch stream state (running / halted on a misaligned target)
//   cnt_w()       : width of a counter that must hold 0..depth inclusive
package fetch_unit_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic              trap;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush and occupancy count.
//   i_clk/i_rst : clock, synchronous active-high reset
//   i_flush     : empty the FIFO; a push in the same cycle lands in the emptied FIFO
//   i_push/i_data : write an entry (caller guarantees space, push+pop on full is legal)
//   i_pop       : drop the head entry (ignored when empty or flushing)
//   o_data      : head entry
//   o_count     : number of stored entries
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = cnt_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wr_idx;
  logic             do_pop;

  always_comb begin
    do_pop   = i_pop && (count_q != '0) && !i_flush;
    wr_idx   = i_flush ? '0 : wr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = i_push ? AW'(1) : '0;
      count_d  = i_push ? CW'(1) : '0;
    end else begin
      if (i_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(i_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[wr_idx] <= i_data;
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a request/response memory port.
//   i_clk/i_rst          : clock, synchronous active-high reset
//   o_imem_req_*         : in-order word fetch requests (valid/ready, addr)
//   i_imem_rsp_*         : in-order responses, at least one cycle after acceptance
//   i_redirect_valid/pc  : redirect the fetch stream; misaligned targets yield a trap entry
//   o_inst_*/i_inst_ready: buffered {inst, pc, trap} to the consumer (valid/ready)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned     DEPTH      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_imem_req_valid,
  input  logic              i_imem_req_ready,
  output logic [PC_W-1:0]   o_imem_req_addr,
  input  logic              i_imem_rsp_valid,
  input  logic [INST_W-1:0] i_imem_rsp_data,
  input  logic              i_redirect_valid,
  input  logic [PC_W-1:0]   i_redirect_pc,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [INST_W-1:0] o_inst,
  output logic [PC_W-1:0]   o_inst_pc,
  output logic              o_inst_trap
);

  localparam int unsigned CW = cnt_w(DEPTH);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CW-1:0]    stale_q, stale_d;

  // Outstanding requests equal the in-flight PC FIFO occupancy, so no separate counter is kept.
  logic [CW-1:0]    outst;
  logic [CW-1:0]    ififo_count;
  logic [CW:0]      credit_used;
  logic [PC_W-1:0]  rsp_pc;
  logic             req_fire;
  logic             misaligned;
  logic             ififo_push;
  fetch_entry_t     ififo_wdata;
  fetch_entry_t     head;

  assign credit_used      = {1'b0, ififo_count} + {1'b0, outst};
  assign misaligned       = i_redirect_pc[1:0] != 2'b00;
  assign o_imem_req_valid = !i_rst && (state_q == FS_RUN) && !i_redirect_valid &&
                            (credit_used < (CW+1)'(DEPTH));
  assign o_imem_req_addr  = pc_q;
  assign req_fire         = o_imem_req_valid && i_imem_req_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    stale_d     = stale_q;
    ififo_push  = 1'b0;
    ififo_wdata = '{inst: i_imem_rsp_data, pc: rsp_pc, trap: 1'b0};
    if (i_redirect_valid) begin
      // This cycle's response is retired here, so it is excluded from the stale count.
      stale_d = outst - CW'(i_imem_rsp_valid);
      if (misaligned) begin
        state_d     = FS_HALT;
        ififo_push  = 1'b1;
        ififo_wdata = '{inst: '0, pc: i_redirect_pc, trap: 1'b1};
      end else begin
        state_d = FS_RUN;
        pc_d    = i_redirect_pc;
      end
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (i_imem_rsp_valid) begin
        if (stale_q != '0) stale_d = stale_q - CW'(1);
        else               ififo_push = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FS_RUN;
      pc_q    <= RESET_ADDR;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && i_imem_rsp_valid) begin
      assert (outst != '0);
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_redirect_valid),
    .i_push  (ififo_push),
    .i_data  (ififo_wdata),
    .i_pop   (o_inst_valid && i_inst_ready),
    .o_data  (head),
    .o_count (ififo_count)
  );

  fetch_fifo #(
    .WIDTH (PC_W),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (1'b0),
    .i_push  (req_fire),
    .i_data  (pc_q),
    .i_pop   (i_imem_rsp_valid),
    .o_data  (rsp_pc),
    .o_count (outst)
  );

  assign o_inst_valid = ififo_count != '0;
  assign o_inst       = o_inst_valid ? head.inst : '0;
  assign o_inst_pc    = o_inst_valid ? head.pc   : '0;
  assign o_inst_trap  = o_inst_valid && head.trap;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_inst_trap;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned nreq   = 0;
  int unsigned nreq_hold;
  bit          rsp_en;
  logic [31:0] pend [$];

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_ADDR (32'h0000_0000),
    .DEPTH      (4)
  ) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_inst_valid     (o_inst_valid),
    .i_inst_ready     (i_inst_ready),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc),
    .o_inst_trap      (o_inst_trap)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // One clock cycle: memory accepts at the edge, answers (in order) right after it.
  task automatic tick();
    logic        f;
    logic [31:0] a;
    @(negedge clk);
    f = o_imem_req_valid && i_imem_req_ready;
    a = o_imem_req_addr;
    if (i_rst) pend.delete();
    @(posedge clk);
    if (f) begin
      pend.push_back(a);
      nreq++;
    end
    #1;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    if (rsp_en && !i_rst && pend.size() > 0) begin
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = mem_word(pend.pop_front());
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    i_rst            = 1'b1;
    i_imem_req_ready = 1'b1;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = '0;
    i_inst_ready     = 1'b1;
    rsp_en           = 1'b1;

    // Reset state
    repeat (3) tick();
    chk1("rst_req_valid", o_imem_req_valid, 1'b0);
    chk1("rst_inst_valid", o_inst_valid, 1'b0);
    chk("rst_inst", o_inst, 32'h0);
    chk("rst_inst_pc", o_inst_pc, 32'h0);
    chk1("rst_inst_trap", o_inst_trap, 1'b0);

    // Streaming: one request per cycle, first instruction two cycles after release
    i_rst = 1'b0;
    #1;
    for (int c = 0; c < 8; c++) begin
      chk1("seq_req_valid", o_imem_req_valid, 1'b1);
      chk("seq_req_addr", o_imem_req_addr, 32'(c * 4));
      if (c >= 2) begin
        chk1("seq_inst_valid", o_inst_valid, 1'b1);
        chk("seq_inst_pc", o_inst_pc, 32'((c - 2) * 4));
        chk("seq_inst", o_inst, mem_word(32'((c - 2) * 4)));
      end else begin
        chk1("seq_inst_valid_early", o_inst_valid, 1'b0);
      end
      tick();
    end

    // Back-pressure: credit limit caps requests at DEPTH
    i_rst = 1'b1;
    repeat (2) tick();
    nreq         = 0;
    i_inst_ready = 1'b0;
    i_rst        = 1'b0;
    repeat (8) tick();
    chk("bp_req_count", 32'(nreq), 32'd4);
    chk1("bp_req_valid", o_imem_req_valid, 1'b0);
    chk1("bp_inst_valid", o_inst_valid, 1'b1);
    chk("bp_inst_pc", o_inst_pc, 32'h0);
    i_inst_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk1("bp_resume_valid", o_inst_valid, 1'b1);
      chk("bp_resume_pc", o_inst_pc, 32'(k * 4));
      chk("bp_resume_inst", o_inst, mem_word(32'(k * 4)));
      tick();
    end

    // Redirect with two fetches in flight
    i_rst = 1'b1;
    repeat (2) tick();
    rsp_en           = 1'b0;
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h10;
    i_rst            = 1'b0;
    #1;
    chk1("rd_suppress0", o_imem_req_valid, 1'b0);
    tick();
    i_redirect_valid = 1'b0;
    #1;
    chk("rd_addr_10", o_imem_req_addr, 32'h10);
    tick();
    chk("rd_addr_14", o_imem_req_addr, 32'h14);
    tick();
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h100;
    rsp_en           = 1'b1;
    #1;
    chk1("rd_suppress1", o_imem_req_valid, 1'b0);
    tick();
    i_redirect_valid = 1'b0;
    #1;
    chk("rd_addr_100", o_imem_req_addr, 32'h100);
    chk1("rd_drop_10", o_inst_valid, 1'b0);
    tick();
    chk1("rd_drop_14", o_inst_valid, 1'b0);
    tick();
    chk1("rd_wait_100", o_inst_valid, 1'b0);
    tick();
    chk1("rd_valid_100", o_inst_valid, 1'b1);
    chk("rd_pc_100", o_inst_pc, 32'h100);
    chk("rd_inst_100", o_inst, mem_word(32'h100));
    tick();
    chk("rd_pc_104", o_inst_pc, 32'h104);

    // Misaligned redirect: single trap entry, fetch halted
    i_inst_ready     = 1'b0;
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h102;
    tick();
    i_redirect_valid = 1'b0;
    #1;
    chk1("trap_valid", o_inst_valid, 1'b1);
    chk1("trap_flag", o_inst_trap, 1'b1);
    chk("trap_pc", o_inst_pc, 32'h102);
    chk("trap_inst", o_inst, 32'h0);
    chk1("trap_no_req", o_imem_req_valid, 1'b0);
    nreq_hold = nreq;
    repeat (5) tick();
    chk("trap_req_count", 32'(nreq), 32'(nreq_hold));
    chk1("trap_halted", o_imem_req_valid, 1'b0);
    chk("trap_pc_held", o_inst_pc, 32'h102);
    chk1("trap_flag_held", o_inst_trap, 1'b1);
    i_inst_ready     = 1'b1;
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h200;
    tick();
    i_redirect_valid = 1'b0;
    #1;
    chk1("resume_flushed", o_inst_valid, 1'b0);
    chk1("resume_req_valid", o_imem_req_valid, 1'b1);
    chk("resume_addr", o_imem_req_addr, 32'h200);
    tick();
    tick();
    chk1("resume_valid", o_inst_valid, 1'b1);
    chk("resume_pc", o_inst_pc, 32'h200);
    chk1("resume_trap", o_inst_trap, 1'b0);

    // Fetch PC wraps from the top of the address space
    i_inst_ready     = 1'b0;
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'hFFFF_FFFC;
    tick();
    i_redirect_valid = 1'b0;
    #1;
    chk("wrap_addr_top", o_imem_req_addr, 32'hFFFF_FFFC);
    tick();
    chk1("wrap_req_valid", o_imem_req_valid, 1'b1);
    chk("wrap_addr_zero", o_imem_req_addr, 32'h0);
    for (int i = 0; i < 10 && o_inst_valid !== 1'b1; i++) tick();
    chk1("wrap_inst_valid", o_inst_valid, 1'b1);
    chk("wrap_pc_top", o_inst_pc, 32'hFFFF_FFFC);
    chk("wrap_inst_top", o_inst, mem_word(32'hFFFF_FFFC));
    i_inst_ready = 1'b1;
    tick();
    chk1("wrap_next_valid", o_inst_valid, 1'b1);
    chk("wrap_pc_zero", o_inst_pc, 32'h0);
    chk("wrap_inst_zero", o_inst, mem_word(32'h0));

    // Reset mid-operation with buffered and outstanding fetches
    i_inst_ready = 1'b0;
    repeat (3) tick();
    chk1("mid_pre_valid", o_inst_valid, 1'b1);
    i_rst = 1'b1;
    tick();
    chk1("mid_rst_inst_valid", o_inst_valid, 1'b0);
    chk1("mid_rst_req_valid", o_imem_req_valid, 1'b0);
    i_rst        = 1'b0;
    i_inst_ready = 1'b1;
    #1;
    chk1("mid_restart_valid", o_imem_req_valid, 1'b1);
    chk("mid_restart_addr", o_imem_req_addr, 32'h0);
    tick();
    tick();
    chk1("mid_restart_inst_valid", o_inst_valid, 1'b1);
    chk("mid_restart_pc", o_inst_pc, 32'h0);
    chk("mid_restart_inst", o_inst, mem_word(32'h0));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
